mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / data) arbiter in front of a single-port synchronous RAM.
// Define ROUND_ROBIN_EN for round-robin tie-breaking; otherwise the data side wins ties.
module mem_arbiter #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 10
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ack,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  // Handshake: a requester raises req (level) with stable addr/data and holds it
  // until its ack pulse; req still high in the cycle after ack is a fresh request.
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] LATCH  = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic OWNER_F = 1'b0;
  localparam logic OWNER_D = 1'b1;

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_wren_q, mem_wren_d;
  logic              f_ack_q, f_ack_d;
  logic              d_ack_q, d_ack_d;
  logic [DATA_W-1:0] f_rdata_q, f_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              grant_d;
  logic              any_req;

`ifdef ROUND_ROBIN_EN
  logic last_q, last_d;

  // On a tie the side that was not granted last time wins.
  always_comb begin
    grant_d = d_req;
    if (f_req && d_req) begin
      grant_d = (last_q == OWNER_F);
    end
  end
`else
  always_comb begin
    grant_d = d_req;
  end
`endif

  assign any_req = f_req | d_req;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    wr_d        = wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wren_d  = 1'b0;
    f_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    f_rdata_d   = f_rdata_q;
    d_rdata_d   = d_rdata_q;
`ifdef ROUND_ROBIN_EN
    last_d      = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (any_req) begin
          owner_d    = grant_d ? OWNER_D : OWNER_F;
          wr_d       = grant_d & d_wr;
          mem_addr_d = grant_d ? d_addr : f_addr;
          mem_wren_d = grant_d & d_wr;
          if (grant_d && d_wr) begin
            mem_wdata_d = d_wdata;
          end
`ifdef ROUND_ROBIN_EN
          last_d = grant_d ? OWNER_D : OWNER_F;
`endif
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        state_d = LATCH;
      end
      LATCH: begin
        // mem_q now reflects the address presented during ACCESS.
        if (owner_q == OWNER_D) begin
          d_ack_d = 1'b1;
          if (!wr_q) begin
            d_rdata_d = mem_q;
          end
        end else begin
          f_ack_d   = 1'b1;
          f_rdata_d = mem_q;
        end
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= IDLE;
      owner_q     <= OWNER_F;
      wr_q        <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wren_q  <= 1'b0;
      f_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      f_rdata_q   <= '0;
      d_rdata_q   <= '0;
`ifdef ROUND_ROBIN_EN
      last_q      <= OWNER_D;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      wr_q        <= wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wren_q  <= mem_wren_d;
      f_ack_q     <= f_ack_d;
      d_ack_q     <= d_ack_d;
      f_rdata_q   <= f_rdata_d;
      d_rdata_q   <= d_rdata_d;
`ifdef ROUND_ROBIN_EN
      last_q      <= last_d;
`endif
    end
  end

  assign f_ack     = f_ack_q;
  assign d_ack     = d_ack_q;
  assign f_rdata   = f_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wren  = mem_wren_q;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model with a shadow memory.
module tb_mem_arbiter;

  logic       clock;
  logic       resetn;
  logic       f_req;
  logic [6:0] f_addr;
  logic       f_ack;
  logic [9:0] f_rdata;
  logic       d_req;
  logic       d_wr;
  logic [6:0] d_addr;
  logic [9:0] d_wdata;
  logic       d_ack;
  logic [9:0] d_rdata;
  logic [6:0] mem_addr;
  logic [9:0] mem_wdata;
  logic       mem_wren;
  logic [9:0] mem_q;
  logic       busy;
  logic [1:0] dbg_state;

  // RAM preload port used only while the DUT is held in reset
  logic       pre_we;
  logic [6:0] pre_addr;
  logic [9:0] pre_data;
  logic [9:0] ram [128];

  int n_cmp;
  int n_err;

  // Reference model state
  logic [9:0] exp_mem [128];
  logic [9:0] exp_f_rdata;
  logic [9:0] exp_d_rdata;
  logic [6:0] exp_mem_addr;
  bit         rr_last_d;

  mem_arbiter #(.ADDR_W(7), .DATA_W(10)) dut (
    .clock(clock), .resetn(resetn),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
    .mem_q(mem_q), .busy(busy), .dbg_state(dbg_state)
  );

  // Clock / reset environment
  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (mem_wren) ram[mem_addr] <= mem_wdata;
    mem_q <= ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic model_reset();
    rr_last_d    = 1'b1;
    exp_f_rdata  = '0;
    exp_d_rdata  = '0;
    exp_mem_addr = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_f_ack"}, 32'(f_ack), 0);
    chk({tag, "_d_ack"}, 32'(d_ack), 0);
    chk({tag, "_mem_wren"}, 32'(mem_wren), 0);
    chk({tag, "_f_rdata"}, 32'(f_rdata), 0);
    chk({tag, "_d_rdata"}, 32'(d_rdata), 0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_mem_wren"}, 32'(mem_wren), 0);
    chk({tag, "_f_ack"}, 32'(f_ack), 0);
    chk({tag, "_d_ack"}, 32'(d_ack), 0);
    chk({tag, "_f_rdata"}, 32'(f_rdata), 32'(exp_f_rdata));
    chk({tag, "_d_rdata"}, 32'(d_rdata), 32'(exp_d_rdata));
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'(exp_mem_addr));
  endtask

  task automatic idle_cycle();
    check_idle("idle");
    next_cycle();
  endtask

  // Driver + checker for one transaction, entered at the IDLE cycle's negedge.
  // keep: winner keeps req high after ack; drop_early: winner drops req in ACCESS.
  task automatic run_txn(input bit keep, input bit drop_early);
    bit         w;
    bit         st;
    logic [6:0] a;
    logic [9:0] wd;
    check_idle("txn_idle");
    if (f_req && d_req) begin
`ifdef ROUND_ROBIN_EN
      w = !rr_last_d;
`else
      w = 1'b1;
`endif
    end else begin
      w = d_req;
    end
    rr_last_d    = w;
    a            = w ? d_addr : f_addr;
    st           = w && d_wr;
    wd           = d_wdata;
    exp_mem_addr = a;

    next_cycle();
    chk("access_busy", 32'(busy), 1);
    chk("access_mem_addr", 32'(mem_addr), 32'(a));
    chk("access_mem_wren", 32'(mem_wren), 32'(st));
    chk("access_f_ack", 32'(f_ack), 0);
    chk("access_d_ack", 32'(d_ack), 0);
    if (st) chk("access_mem_wdata", 32'(mem_wdata), 32'(wd));
    if (drop_early) begin
      if (w) d_req = 1'b0;
      else f_req = 1'b0;
    end

    next_cycle();
    chk("latch_busy", 32'(busy), 1);
    chk("latch_mem_wren", 32'(mem_wren), 0);
    chk("latch_mem_addr", 32'(mem_addr), 32'(a));
    chk("latch_f_ack", 32'(f_ack), 0);
    chk("latch_d_ack", 32'(d_ack), 0);
    chk("latch_f_rdata", 32'(f_rdata), 32'(exp_f_rdata));
    chk("latch_d_rdata", 32'(d_rdata), 32'(exp_d_rdata));
    if (st) exp_mem[a] = wd;
    else if (w) exp_d_rdata = exp_mem[a];
    else exp_f_rdata = exp_mem[a];

    next_cycle();
    chk("done_busy", 32'(busy), 1);
    chk("done_mem_wren", 32'(mem_wren), 0);
    chk("done_f_ack", 32'(f_ack), 32'(!w));
    chk("done_d_ack", 32'(d_ack), 32'(w));
    chk("done_f_rdata", 32'(f_rdata), 32'(exp_f_rdata));
    chk("done_d_rdata", 32'(d_rdata), 32'(exp_d_rdata));
    if (!keep) begin
      if (w) d_req = 1'b0;
      else f_req = 1'b0;
    end

    next_cycle();
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    resetn  = 1'b0;
    f_req   = 1'b0;
    f_addr  = '0;
    d_req   = 1'b0;
    d_wr    = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    pre_we  = 1'b0;
    pre_addr = '0;
    pre_data = '0;
    @(negedge clock);

    // Preload RAM under reset
    for (int i = 0; i < 128; i++) begin
      pre_we   = 1'b1;
      pre_addr = 7'(i);
      pre_data = (i == 5) ? 10'h2A5 : 10'($urandom_range(0, 1023));
      exp_mem[i] = pre_data;
      next_cycle();
    end
    pre_we = 1'b0;
    model_reset();
    check_reset_outputs("reset");
    resetn = 1'b1;

    // Single fetch from address 5
    f_req = 1'b1; f_addr = 7'd5;
    run_txn(1'b0, 1'b0);
    chk("fetch5_rdata", 32'(f_rdata), 32'h2A5);

    // Store 0x155 to 9, then load it back
    d_req = 1'b1; d_wr = 1'b1; d_addr = 7'd9; d_wdata = 10'h155;
    run_txn(1'b0, 1'b0);
    chk("store_keeps_d_rdata", 32'(d_rdata), 0);
    d_req = 1'b1; d_wr = 1'b0; d_addr = 7'd9;
    run_txn(1'b0, 1'b0);
    chk("load9_rdata", 32'(d_rdata), 32'h155);

    // Back-to-back loads from 1 then 2
    d_req = 1'b1; d_wr = 1'b0; d_addr = 7'd1;
    run_txn(1'b1, 1'b0);
    d_addr = 7'd2;
    run_txn(1'b0, 1'b0);

    // Tie after a fresh reset: both held for three grants, then data drops
    resetn = 1'b0;
    next_cycle();
    model_reset();
    check_reset_outputs("reset2");
    resetn = 1'b1;
    f_req = 1'b1; f_addr = 7'd3;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 7'd4;
    for (int i = 0; i < 3; i++) run_txn(1'b1, 1'b0);
    d_req = 1'b0;
    run_txn(1'b0, 1'b0);
    idle_cycle();

    // Reset during LATCH of a fetch aborts it without ack
    f_req = 1'b1; f_addr = 7'd7;
    check_idle("abort_idle");
    next_cycle();
    next_cycle();
    resetn = 1'b0;
    f_req  = 1'b0;
    next_cycle();
    model_reset();
    check_reset_outputs("abort");
    resetn = 1'b1;
    f_req = 1'b1; f_addr = 7'd7;
    run_txn(1'b0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 80; i++) begin
      bit keep;
      if (!f_req && ($urandom_range(0, 1) == 1)) begin
        f_req  = 1'b1;
        f_addr = 7'($urandom_range(0, 15));
      end
      if (!d_req && ($urandom_range(0, 1) == 1)) begin
        d_req   = 1'b1;
        d_wr    = 1'($urandom_range(0, 1));
        d_addr  = 7'($urandom_range(0, 15));
        d_wdata = 10'($urandom_range(0, 1023));
      end
      if (!f_req && !d_req) begin
        idle_cycle();
      end else begin
        keep = ($urandom_range(0, 3) == 0);
        run_txn(keep, !keep && ($urandom_range(0, 4) == 0));
      end
    end
    f_req = 1'b0;
    d_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (busy) next_cycle();
    end
    check_idle("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
